// File: rtl/dma_stim_sequencer.sv
// Table-driven stimulus sequencer that replays a run-time loaded step table onto the ADMA control inputs.
// Define DMA_SEQ_LOOP_EN to replay the table LOOP_COUNT times and expose o_loop_cnt.
module dma_stim_sequencer #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DEPTH       = 8,
    parameter int DELAY_WIDTH = 16,
    parameter int RST_CYCLES  = 2,
`ifdef DMA_SEQ_LOOP_EN
    parameter int LOOP_COUNT  = 2,
`endif
    parameter int IDX_W       = $clog2(DEPTH),
    parameter int ENTRY_W     = ADDR_WIDTH + DELAY_WIDTH + 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tbl_wr_en,
    input  logic [IDX_W-1:0]      i_tbl_wr_idx,
    input  logic [ENTRY_W-1:0]    i_tbl_wr_data,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_xfer_done,
    output logic                  o_dma_reset,
    output logic                  o_stop,
    output logic                  o_command_reg_write,
    output logic                  o_command_reg_continue,
    output logic                  o_direction,
    output logic [ADDR_WIDTH-1:0] o_starting_address,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [IDX_W-1:0]      o_step_idx
`ifdef DMA_SEQ_LOOP_EN
    ,
    output logic [7:0]            o_loop_cnt
`endif
);

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [DELAY_WIDTH-1:0] RST_LAST = DELAY_WIDTH'(RST_CYCLES - 1);
    localparam int                     F_WR     = ADDR_WIDTH + DELAY_WIDTH;
`ifdef DMA_SEQ_LOOP_EN
    localparam logic [7:0]             LOOP_LAST = 8'(LOOP_COUNT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DMA,
        S_LOAD,
        S_HOLD,
        S_WAIT_DN,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                  r_state, w_state;
    logic [DELAY_WIDTH-1:0]  r_cnt, w_cnt;
    logic [IDX_W-1:0]        r_step_idx, w_step_idx;
    logic                    r_dma_reset, w_dma_reset;
    logic                    r_stop, w_stop;
    logic                    r_wr, w_wr;
    logic                    r_cont, w_cont;
    logic                    r_dir, w_dir;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
`ifdef DMA_SEQ_LOOP_EN
    logic [7:0]              r_loop_cnt, w_loop_cnt;
`endif

    logic [ENTRY_W-1:0]      r_table [DEPTH];
    logic [ENTRY_W-1:0]      w_entry;
    logic [DELAY_WIDTH-1:0]  w_delay;
    logic [DELAY_WIDTH-1:0]  w_hold_init;
    logic                    w_busy;
    logic                    w_last_step;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign w_entry = r_table[r_step_idx];
    assign w_delay = w_entry[ADDR_WIDTH +: DELAY_WIDTH];
    // HOLD exits on counter==0, so preload delay-1; delay 0 and 1 both give one HOLD cycle.
    assign w_hold_init = (w_delay == '0) ? '0 : w_delay - 1'b1;
    assign w_last_step = w_entry[F_WR + 5] || (r_step_idx == LAST_IDX);

    // Table contents deliberately have no reset and are frozen while a sequence runs.
    always_ff @(posedge i_clk) begin
        if (i_tbl_wr_en && !w_busy) begin
            r_table[i_tbl_wr_idx] <= i_tbl_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_step_idx  <= '0;
            r_dma_reset <= 1'b1;
            r_stop      <= 1'b0;
            r_wr        <= 1'b0;
            r_cont      <= 1'b0;
            r_dir       <= 1'b1;
            r_addr      <= '0;
`ifdef DMA_SEQ_LOOP_EN
            r_loop_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_step_idx  <= w_step_idx;
            r_dma_reset <= w_dma_reset;
            r_stop      <= w_stop;
            r_wr        <= w_wr;
            r_cont      <= w_cont;
            r_dir       <= w_dir;
            r_addr      <= w_addr;
`ifdef DMA_SEQ_LOOP_EN
            r_loop_cnt  <= w_loop_cnt;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_step_idx  = r_step_idx;
        w_dma_reset = r_dma_reset;
        w_stop      = r_stop;
        w_wr        = r_wr;
        w_cont      = r_cont;
        w_dir       = r_dir;
        w_addr      = r_addr;
`ifdef DMA_SEQ_LOOP_EN
        w_loop_cnt  = r_loop_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state    = S_RST_DMA;
                    w_cnt      = '0;
                    w_step_idx = '0;
`ifdef DMA_SEQ_LOOP_EN
                    w_loop_cnt = '0;
`endif
                end
            end
            S_RST_DMA: begin
                w_dma_reset = 1'b1;
                if (r_cnt == RST_LAST) begin
                    w_state = S_LOAD;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                w_dma_reset = 1'b0;
                w_addr      = w_entry[ADDR_WIDTH-1:0];
                w_wr        = w_entry[F_WR];
                w_cont      = w_entry[F_WR + 1];
                w_dir       = w_entry[F_WR + 2];
                w_stop      = w_entry[F_WR + 3];
                w_cnt       = w_hold_init;
                w_state     = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state = w_entry[F_WR + 4] ? S_WAIT_DN : S_NEXT;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_WAIT_DN: begin
                if (i_xfer_done) begin
                    w_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (w_last_step) begin
`ifdef DMA_SEQ_LOOP_EN
                    if (r_loop_cnt < LOOP_LAST) begin
                        w_loop_cnt = r_loop_cnt + 8'd1;
                        w_step_idx = '0;
                        w_state    = S_LOAD;
                    end else begin
                        w_state = S_FINISH;
                    end
`else
                    w_state = S_FINISH;
`endif
                end else begin
                    w_step_idx = r_step_idx + 1'b1;
                    w_state    = S_LOAD;
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Abort overrides every busy state and freezes the step position and address.
        if (i_abort && w_busy) begin
            w_state    = S_FINISH;
            w_stop     = 1'b1;
            w_wr       = 1'b0;
            w_cont     = 1'b0;
            w_dir      = r_dir;
            w_addr     = r_addr;
            w_step_idx = r_step_idx;
`ifdef DMA_SEQ_LOOP_EN
            w_loop_cnt = r_loop_cnt;
`endif
        end
    end

    assign o_dma_reset            = r_dma_reset;
    assign o_stop                 = r_stop;
    assign o_command_reg_write    = r_wr;
    assign o_command_reg_continue = r_cont;
    assign o_direction            = r_dir;
    assign o_starting_address     = r_addr;
    assign o_busy                 = w_busy;
    assign o_done                 = (r_state == S_FINISH);
    assign o_step_idx             = r_step_idx;
`ifdef DMA_SEQ_LOOP_EN
    assign o_loop_cnt             = r_loop_cnt;
`endif

endmodule

// File: tb/tb_dma_stim_sequencer.sv
// Directed-vector testbench for dma_stim_sequencer with hand-computed expectations.
// Covers the DMA_SEQ_LOOP_EN build as well when that macro is defined.
module tb_dma_stim_sequencer;

    logic        clock;
    logic        resetN;
    logic        tblWrEn;
    logic [2:0]  tblWrIdx;
    logic [85:0] tblWrData;
    logic        start;
    logic        abort;
    logic        xferDone;
    logic        dmaReset;
    logic        stop;
    logic        cmdWrite;
    logic        cmdContinue;
    logic        direction;
    logic [63:0] startAddr;
    logic        busy;
    logic        done;
    logic [2:0]  stepIdx;
`ifdef DMA_SEQ_LOOP_EN
    logic [7:0]  loopCnt;
`endif

    int vecCount = 0;
    int errCount = 0;

    dma_stim_sequencer #(
        .ADDR_WIDTH (64),
        .DEPTH      (8),
        .DELAY_WIDTH(16),
`ifdef DMA_SEQ_LOOP_EN
        .LOOP_COUNT (3),
`endif
        .RST_CYCLES (2)
    ) dut (
        .i_clk                 (clock),
        .i_rst_n               (resetN),
        .i_tbl_wr_en           (tblWrEn),
        .i_tbl_wr_idx          (tblWrIdx),
        .i_tbl_wr_data         (tblWrData),
        .i_start               (start),
        .i_abort               (abort),
        .i_xfer_done           (xferDone),
        .o_dma_reset           (dmaReset),
        .o_stop                (stop),
        .o_command_reg_write   (cmdWrite),
        .o_command_reg_continue(cmdContinue),
        .o_direction           (direction),
        .o_starting_address    (startAddr),
        .o_busy                (busy),
        .o_done                (done),
`ifdef DMA_SEQ_LOOP_EN
        .o_loop_cnt            (loopCnt),
`endif
        .o_step_idx            (stepIdx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Field order is {LAST, WAIT, STOP, DIR, CONT, WR, delay, addr}.
    function automatic logic [85:0] makeEntry(input logic last, input logic waitBit,
                                              input logic stopBit, input logic dir,
                                              input logic cont, input logic wr,
                                              input logic [15:0] dly, input logic [63:0] addr);
        return {last, waitBit, stopBit, dir, cont, wr, dly, addr};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled only on the falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic writeEntry(input logic [2:0] idx, input logic [85:0] data);
        tblWrEn   = 1'b1;
        tblWrIdx  = idx;
        tblWrData = data;
        @(negedge clock);
        tblWrEn   = 1'b0;
    endtask

`ifdef DMA_SEQ_LOOP_EN
    task automatic runLoopTest;
        logic [63:0] seq[$];
        logic [63:0] lastAddr;
        logic        prevReset;
        int          resetRises;
        bit          doneSeen;
        resetN = 1'b0;
        tick(2);
        resetN = 1'b1;
        checkOutput("loop_cnt_reset", 64'(loopCnt), 64'd0);
        writeEntry(3'd0, makeEntry(0, 0, 0, 0, 0, 1, 16'd0, 64'h10));
        writeEntry(3'd1, makeEntry(1, 0, 0, 0, 0, 1, 16'd0, 64'h20));
        lastAddr   = startAddr;
        prevReset  = dmaReset;
        resetRises = 0;
        doneSeen   = 1'b0;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 200 && !doneSeen; c++) begin
            if (startAddr != lastAddr) begin
                seq.push_back(startAddr);
                lastAddr = startAddr;
            end
            if (!prevReset && dmaReset) resetRises++;
            prevReset = dmaReset;
            if (done) doneSeen = 1'b1;
            else tick(1);
        end
        checkOutput("loop_done_in_budget", 64'(doneSeen), 64'd1);
        checkOutput("loop_entry_count", 64'(seq.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < seq.size())
                checkOutput($sformatf("loop_entry_%0d", i), seq[i], (i % 2) ? 64'h20 : 64'h10);
        end
        checkOutput("loop_cnt_final", 64'(loopCnt), 64'd2);
        checkOutput("loop_single_reset_phase", 64'(resetRises), 64'd0);
        tick(1);
    endtask
`endif

    initial begin
        resetN    = 1'b0;
        tblWrEn   = 1'b0;
        tblWrIdx  = '0;
        tblWrData = '0;
        start     = 1'b0;
        abort     = 1'b0;
        xferDone  = 1'b0;

        // Reset values
        tick(2);
        checkOutput("rst_dma_reset", 64'(dmaReset), 64'd1);
        checkOutput("rst_direction", 64'(direction), 64'd1);
        checkOutput("rst_address", startAddr, 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_stop_wr", {62'd0, stop, cmdWrite}, 64'd0);
        checkOutput("rst_step_idx", 64'(stepIdx), 64'd0);
        resetN = 1'b1;
        tick(1);

        // Three-step timed sequence, start edge is t
        writeEntry(3'd0, makeEntry(0, 0, 0, 1, 0, 1, 16'd20, 64'h0));
        writeEntry(3'd1, makeEntry(0, 0, 0, 0, 0, 1, 16'd30, 64'h100));
        writeEntry(3'd2, makeEntry(1, 0, 1, 0, 0, 0, 16'd2, 64'h200));
        applyStimulus(1'b1, 1'b0);
        checkOutput("seq_busy_t", 64'(busy), 64'd1);
        tick(2);
        checkOutput("seq_dma_reset_t2", 64'(dmaReset), 64'd1);
        checkOutput("seq_wr_t2", 64'(cmdWrite), 64'd0);
        tick(1);
        checkOutput("seq_dma_reset_t3", 64'(dmaReset), 64'd0);
        checkOutput("seq_wr_t3", 64'(cmdWrite), 64'd1);
        tick(21);
        checkOutput("seq_dir_t24", 64'(direction), 64'd1);
        tick(1);
        checkOutput("seq_dir_t25", 64'(direction), 64'd0);
        checkOutput("seq_addr_t25", startAddr, 64'h100);
        checkOutput("seq_step_t25", 64'(stepIdx), 64'd1);
        tick(31);
        checkOutput("seq_stop_t56", 64'(stop), 64'd0);
        tick(1);
        checkOutput("seq_stop_t57", 64'(stop), 64'd1);
        checkOutput("seq_step_t57", 64'(stepIdx), 64'd2);
        tick(2);
        checkOutput("seq_done_t59", 64'(done), 64'd0);
        tick(1);
        checkOutput("seq_done_t60", 64'(done), 64'd1);
        checkOutput("seq_busy_t60", 64'(busy), 64'd0);
        tick(1);
        checkOutput("seq_done_t61", 64'(done), 64'd0);
        checkOutput("seq_hold_addr", startAddr, 64'h200);
        checkOutput("seq_hold_stop", 64'(stop), 64'd1);

        // Wait on xfer_done
        writeEntry(3'd0, makeEntry(0, 1, 0, 1, 0, 1, 16'd0, 64'h0));
        writeEntry(3'd1, makeEntry(1, 0, 0, 1, 0, 0, 16'd0, 64'h300));
        applyStimulus(1'b1, 1'b0);
        tick(3);
        checkOutput("wait_wr_t3", 64'(cmdWrite), 64'd1);
        tick(50);
        checkOutput("wait_step_t53", 64'(stepIdx), 64'd0);
        checkOutput("wait_busy_t53", 64'(busy), 64'd1);
        xferDone = 1'b1;
        tick(1);
        checkOutput("wait_step_seen", 64'(stepIdx), 64'd0);
        tick(1);
        xferDone = 1'b0;
        checkOutput("wait_step_adv", 64'(stepIdx), 64'd1);
        tick(1);
        checkOutput("wait_addr_e1", startAddr, 64'h300);
        tick(2);
        checkOutput("wait_done", 64'(done), 64'd1);
        tick(1);

        // Abort during HOLD of entry 1
        writeEntry(3'd0, makeEntry(0, 0, 0, 1, 0, 1, 16'd20, 64'h0));
        writeEntry(3'd1, makeEntry(0, 0, 0, 0, 1, 1, 16'd30, 64'h100));
        writeEntry(3'd2, makeEntry(1, 0, 1, 0, 0, 0, 16'd2, 64'h200));
        applyStimulus(1'b1, 1'b0);
        tick(30);
        checkOutput("abort_cont_before", 64'(cmdContinue), 64'd1);
        checkOutput("abort_stop_before", 64'(stop), 64'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_stop", 64'(stop), 64'd1);
        checkOutput("abort_wr", 64'(cmdWrite), 64'd0);
        checkOutput("abort_cont", 64'(cmdContinue), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd1);
        checkOutput("abort_step", 64'(stepIdx), 64'd1);
        tick(1);
        checkOutput("abort_done_end", 64'(done), 64'd0);
        checkOutput("abort_step_frozen", 64'(stepIdx), 64'd1);

        // Table write and start while busy are ignored
        applyStimulus(1'b1, 1'b0);
        tick(4);
        writeEntry(3'd1, makeEntry(0, 0, 0, 1, 0, 1, 16'd5, 64'hDEAD));
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_start_dma_reset", 64'(dmaReset), 64'd0);
        checkOutput("busy_start_step", 64'(stepIdx), 64'd0);
        tick(20);
        checkOutput("busy_wr_addr_run1", startAddr, 64'h100);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        applyStimulus(1'b1, 1'b0);
        tick(25);
        checkOutput("busy_wr_addr_run2", startAddr, 64'h100);
        applyStimulus(1'b0, 1'b1);
        tick(2);

        // start+abort together in IDLE does nothing
        applyStimulus(1'b1, 1'b1);
        checkOutput("idle_sa_busy", 64'(busy), 64'd0);
        tick(2);
        checkOutput("idle_sa_busy_later", 64'(busy), 64'd0);
        checkOutput("idle_sa_dma_reset", 64'(dmaReset), 64'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("idle_abort_done", 64'(done), 64'd0);

        // Reset in the middle of a sequence
        applyStimulus(1'b1, 1'b0);
        tick(5);
        resetN = 1'b0;
        tick(1);
        checkOutput("midrst_dma_reset", 64'(dmaReset), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_wr", 64'(cmdWrite), 64'd0);
        checkOutput("midrst_addr", startAddr, 64'd0);
        resetN = 1'b1;
        tick(1);
        checkOutput("midrst_no_done", 64'(done), 64'd0);

`ifdef DMA_SEQ_LOOP_EN
        runLoopTest();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
